// File: rtl/obstacle_pkg.sv
// obstacle_pkg: shared types and constants for the obstacle spawner slice.
//   obs_t    : one obstacle table entry {valid, x, gap_top}
//   state_t  : spawner FSM states (IDLE, SCROLL, SPAWN)
//   X_W/Y_W  : screen coordinate widths
//   GAP_H    : vertical gap height, used by the optional collision check
//              (enabled with the OBSTACLE_COLLIDE_EN macro in obstacle_spawner)
package obstacle_pkg;

  localparam int X_W   = 10;
  localparam int Y_W   = 9;
  localparam int GAP_H = 96;

  typedef struct packed {
    logic           valid;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] gap_top;
  } obs_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCROLL = 2'd1,
    ST_SPAWN  = 2'd2
  } state_t;

  // gap_top = gmin + r * gscale, truncated to the Y coordinate width.
  function automatic logic [Y_W-1:0] gap_from_rand(input logic [5:0] r,
                                                   input int gmin,
                                                   input int gscale);
    return Y_W'(gmin + int'(r) * gscale);
  endfunction

endpackage

// File: rtl/obstacle_table.sv
// obstacle_table: NUM_OBS-entry register file of obstacles.
//   clk, aclr   : clock, asynchronous active-low reset (all entries zeroed)
//   clear_all   : synchronous clear of every entry, wins over the write
//   wr_en/wr_idx/wr_data : single write port
//   rd_idx/rd_data       : combinational read port for the renderer
//   slots       : whole table, combinational, for the spawner's scan logic
module obstacle_table
  import obstacle_pkg::*;
#(
  parameter int NUM_OBS = 4,
  localparam int IDX_W  = $clog2(NUM_OBS)
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic             clear_all,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  obs_t             wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output obs_t             rd_data,
  output obs_t             slots [NUM_OBS]
);

  obs_t mem [NUM_OBS];

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      for (int i = 0; i < NUM_OBS; i++) mem[i] <= '0;
    end else if (clear_all) begin
      for (int i = 0; i < NUM_OBS; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];
  assign slots   = mem;

endmodule

// File: rtl/obstacle_spawner.sv
// obstacle_spawner: per-frame obstacle scroll / retire / spawn engine.
//   clk, aclr      : clock, asynchronous active-low reset
//   clear          : synchronous restart (table, timer, counters, FSM)
//   run            : frame ticks are only honoured while high
//   frame_tick     : one-cycle pulse per video frame
//   rand_in        : shift register value, bits [5:0] pick the gap position
//   rand_en        : one-cycle pulse per consumed random value (every spawn)
//   busy           : high while a frame update is running
//   rd_idx/rd_valid/rd_x/rd_gap_top : combinational table read port
//   spawn_count    : spawns since clear, saturating
//   overflow       : sticky, a spawn found no free slot
//   dbg_state      : current FSM state
// Optional feature macro OBSTACLE_COLLIDE_EN adds heli_y, heli_x and the
// sticky hit output.
//
// Frame timing: tick sampled at edge T, slot i rewritten at edge T+1+i,
// spawn write and rand_en pulse at edge T+1+NUM_OBS.
module obstacle_spawner
  import obstacle_pkg::*;
#(
  parameter int NUM_OBS      = 4,
  parameter int SCREEN_W     = 640,
  parameter int SPEED        = 4,
  parameter int SPAWN_FRAMES = 40,
  parameter int GAP_MIN      = 32,
  parameter int GAP_SCALE    = 4
) (
  input  logic                       clk,
  input  logic                       aclr,
  input  logic                       clear,
  input  logic                       run,
  input  logic                       frame_tick,
  input  logic [31:0]                rand_in,
  output logic                       rand_en,
  output logic                       busy,
  input  logic [$clog2(NUM_OBS)-1:0] rd_idx,
  output logic                       rd_valid,
  output logic [X_W-1:0]             rd_x,
  output logic [Y_W-1:0]             rd_gap_top,
  output logic [15:0]                spawn_count,
  output logic                       overflow,
`ifdef OBSTACLE_COLLIDE_EN
  input  logic [Y_W-1:0]             heli_y,
  input  logic [X_W-1:0]             heli_x,
  output logic                       hit,
`endif
  output state_t                     dbg_state
);

  localparam int IDX_W = $clog2(NUM_OBS);
  localparam int TW    = $clog2(SPAWN_FRAMES + 1);

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [TW-1:0]    spawn_timer;

  obs_t             slots [NUM_OBS];
  obs_t             cur;
  obs_t             rd_data;
  logic [X_W-1:0]   moved_x;
  logic             retire;

  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  obs_t             wr_data;

  logic             free_found;
  logic [IDX_W-1:0] free_idx;

  logic             unused_rand_bits;
  assign unused_rand_bits = ^rand_in[31:6];

  obstacle_table #(.NUM_OBS(NUM_OBS)) u_table (
    .clk      (clk),
    .aclr     (aclr),
    .clear_all(clear),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_data  (wr_data),
    .rd_idx   (rd_idx),
    .rd_data  (rd_data),
    .slots    (slots)
  );

  assign rd_valid   = rd_data.valid;
  assign rd_x       = rd_data.x;
  assign rd_gap_top = rd_data.gap_top;
  assign dbg_state  = state;

  assign cur     = slots[ptr];
  assign moved_x = cur.x - X_W'(SPEED);
  // A slot that would scroll past x=0 leaves the screen this frame.
  assign retire  = cur.x < X_W'(SPEED);

  // Lowest-index free slot: scan downwards so the last hit is the lowest.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_OBS - 1; i >= 0; i--) begin
      if (!slots[i].valid) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  // Table write port, decided from the current state and applied at the edge.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = ptr;
    wr_data = cur;
    case (state)
      ST_SCROLL: begin
        if (cur.valid) begin
          wr_en = 1'b1;
          if (retire) wr_data = '0;
          else        wr_data.x = moved_x;
        end
      end
      ST_SPAWN: begin
        if (free_found) begin
          wr_en           = 1'b1;
          wr_idx          = free_idx;
          wr_data.valid   = 1'b1;
          wr_data.x       = X_W'(SCREEN_W - 1);
          wr_data.gap_top = gap_from_rand(rand_in[5:0], GAP_MIN, GAP_SCALE);
        end
      end
      default: ;
    endcase
    if (clear) wr_en = 1'b0;
  end

`ifdef OBSTACLE_COLLIDE_EN
  logic [X_W:0] heli_x_end;
  logic [Y_W:0] gap_end;
  logic         collide;

  assign heli_x_end = {1'b0, heli_x} + 11'd15;
  assign gap_end    = {1'b0, cur.gap_top} + 10'(GAP_H - 1);
  // Uses the post-move x of a slot that stays on screen this frame.
  assign collide = (state == ST_SCROLL) && cur.valid && !retire &&
                   ({1'b0, moved_x} >= {1'b0, heli_x}) &&
                   ({1'b0, moved_x} <= heli_x_end) &&
                   ((heli_y < cur.gap_top) || ({1'b0, heli_y} > gap_end));
`endif

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      spawn_timer <= TW'(SPAWN_FRAMES);
      busy        <= 1'b0;
      rand_en     <= 1'b0;
      spawn_count <= '0;
      overflow    <= 1'b0;
`ifdef OBSTACLE_COLLIDE_EN
      hit         <= 1'b0;
`endif
    end else if (clear) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      spawn_timer <= TW'(SPAWN_FRAMES);
      busy        <= 1'b0;
      rand_en     <= 1'b0;
      spawn_count <= '0;
      overflow    <= 1'b0;
`ifdef OBSTACLE_COLLIDE_EN
      hit         <= 1'b0;
`endif
    end else begin
      rand_en <= 1'b0;
`ifdef OBSTACLE_COLLIDE_EN
      if (collide) hit <= 1'b1;
`endif
      case (state)
        ST_IDLE: begin
          if (frame_tick && run) begin
            state <= ST_SCROLL;
            ptr   <= '0;
            busy  <= 1'b1;
          end
        end
        ST_SCROLL: begin
          ptr <= ptr + IDX_W'(1);
          if (ptr == IDX_W'(NUM_OBS - 1)) begin
            if (spawn_timer == TW'(1)) begin
              spawn_timer <= TW'(SPAWN_FRAMES);
              state       <= ST_SPAWN;
            end else begin
              spawn_timer <= spawn_timer - TW'(1);
              state       <= ST_IDLE;
              busy        <= 1'b0;
            end
          end
        end
        ST_SPAWN: begin
          // The random value is consumed even when the table is full.
          rand_en <= 1'b1;
          if (spawn_count != 16'hFFFF) spawn_count <= spawn_count + 16'd1;
          if (!free_found) overflow <= 1'b1;
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_obstacle_spawner.sv
module tb_obstacle_spawner;
  import obstacle_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic aclr = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- DUT a: default parameters ----------------
  logic        a_clear = 0, a_run = 0, a_tick_in = 0;
  logic [31:0] a_rand = 0;
  logic [1:0]  a_rd_idx = 0;
  logic        a_rand_en, a_busy, a_rd_valid, a_overflow;
  logic [9:0]  a_rd_x;
  logic [8:0]  a_rd_gap;
  logic [15:0] a_spawn_count;
  state_t      a_dbg_state;
`ifdef OBSTACLE_COLLIDE_EN
  logic [8:0]  a_heli_y = 0;
  logic [9:0]  a_heli_x = 0;
  logic        a_hit;
`endif

  obstacle_spawner u_a (
    .clk(clk), .aclr(aclr), .clear(a_clear), .run(a_run), .frame_tick(a_tick_in),
    .rand_in(a_rand), .rand_en(a_rand_en), .busy(a_busy), .rd_idx(a_rd_idx),
    .rd_valid(a_rd_valid), .rd_x(a_rd_x), .rd_gap_top(a_rd_gap),
    .spawn_count(a_spawn_count), .overflow(a_overflow),
`ifdef OBSTACLE_COLLIDE_EN
    .heli_y(a_heli_y), .heli_x(a_heli_x), .hit(a_hit),
`endif
    .dbg_state(a_dbg_state)
  );

  // ---------------- DUT b: spawn every frame, slow scroll ----------------
  logic        b_clear = 0, b_run = 1, b_tick_in = 0;
  logic [31:0] b_rand = 0;
  logic [1:0]  b_rd_idx = 0;
  logic        b_rand_en, b_busy, b_rd_valid, b_overflow;
  logic [9:0]  b_rd_x;
  logic [8:0]  b_rd_gap;
  logic [15:0] b_spawn_count;
  state_t      b_dbg_state;
`ifdef OBSTACLE_COLLIDE_EN
  logic        b_hit;
`endif

  obstacle_spawner #(.SPAWN_FRAMES(1), .SPEED(1)) u_b (
    .clk(clk), .aclr(aclr), .clear(b_clear), .run(b_run), .frame_tick(b_tick_in),
    .rand_in(b_rand), .rand_en(b_rand_en), .busy(b_busy), .rd_idx(b_rd_idx),
    .rd_valid(b_rd_valid), .rd_x(b_rd_x), .rd_gap_top(b_rd_gap),
    .spawn_count(b_spawn_count), .overflow(b_overflow),
`ifdef OBSTACLE_COLLIDE_EN
    .heli_y(9'd0), .heli_x(10'd0), .hit(b_hit),
`endif
    .dbg_state(b_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];   // {tick-to-pulse latency, 8'h0, spawn_count}
  int tick_cyc = 0;
  int tick_no  = 0;
  int exp_count = 0;
  int b_pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Monitor: every rand_en pulse from DUT a must match the next expectation.
  always @(negedge clk) begin
    if (a_rand_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rand_en: pulse at cycle %0d, expected none", cyc);
      end else begin
        check("rand_en_pulse", {8'(cyc - tick_cyc), 8'h00, a_spawn_count}, exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) if (b_rand_en === 1'b1) b_pulses++;

  // ---------------- drivers ----------------
  task automatic a_tick(input bit probe);
    bit sp;
    int n;
    tick_no++;
    sp = (tick_no % 40 == 0);
    @(negedge clk);
    a_tick_in = 1'b1;
    tick_cyc = cyc + 1;
    if (sp) begin
      exp_count++;
      exp_q.push_back({8'd5, 8'h00, 16'(exp_count)});
    end
    @(negedge clk);
    a_tick_in = 1'b0;
    n = 0;
    while (a_busy && n < 20) begin
      n++;
      if (probe && n == 2) check("retire_mid_frame_valid", a_rd_valid, 0);
      @(negedge clk);
    end
    check(sp ? "busy_len_spawn" : "busy_len", n, sp ? 5 : 4);
  endtask

  task automatic a_ticks(input int n);
    for (int i = 0; i < n; i++) a_tick(1'b0);
  endtask

  task automatic a_slot(input int idx, input logic v, input int x, input int g);
    a_rd_idx = 2'(idx);
    #1;
    check($sformatf("a_slot%0d_valid", idx), a_rd_valid, v);
    check($sformatf("a_slot%0d_x", idx), a_rd_x, x);
    check($sformatf("a_slot%0d_gap", idx), a_rd_gap, g);
  endtask

  task automatic b_tick();
    @(negedge clk);
    b_tick_in = 1'b1;
    @(negedge clk);
    b_tick_in = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic b_slot(input int idx, input int x, input int g);
    b_rd_idx = 2'(idx);
    #1;
    check($sformatf("b_slot%0d_valid", idx), b_rd_valid, 1);
    check($sformatf("b_slot%0d_x", idx), b_rd_x, x);
    check($sformatf("b_slot%0d_gap", idx), b_rd_gap, g);
  endtask

  task automatic a_clear_pulse();
    @(negedge clk);
    a_clear = 1'b1;
    @(negedge clk);
    a_clear = 1'b0;
    tick_no = 0;
    exp_count = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(negedge clk);
    aclr = 1'b1;
    repeat (2) @(negedge clk);

    // reset values
    check("rst_busy", a_busy, 0);
    check("rst_rand_en", a_rand_en, 0);
    check("rst_spawn_count", a_spawn_count, 0);
    check("rst_overflow", a_overflow, 0);
    check("rst_state", a_dbg_state, ST_IDLE);
    for (int i = 0; i < 4; i++) a_slot(i, 1'b0, 0, 0);

    // idle without ticks, then a tick with run low: nothing happens
    repeat (10) @(negedge clk);
    a_tick_in = 1'b1;
    @(negedge clk);
    a_tick_in = 1'b0;
    check("run_low_busy", a_busy, 0);
    repeat (3) @(negedge clk);

    // first spawn on the 40th running tick
    a_run = 1'b1;
    a_rand = 32'h0000_0005;
    a_ticks(40);
    check("spawn_count_1", a_spawn_count, 1);
    a_slot(0, 1'b1, 639, 52);
    a_slot(1, 1'b0, 0, 0);

    // scroll 10 frames
    a_ticks(10);
    a_slot(0, 1'b1, 599, 52);

    // scroll until slot 0 sits at x=3
    a_ticks(149);
    a_slot(0, 1'b1, 3, 52);
    a_slot(1, 1'b1, 163, 52);

    // tick 200: slot 0 retires at T+1, then the spawn reuses slot 0
    a_rand = 32'hFFFF_FFFF;
    a_rd_idx = 2'd0;
    a_tick(1'b1);
    a_slot(0, 1'b1, 639, 284);
    check("spawn_count_5", a_spawn_count, 5);
    check("overflow_still_0", a_overflow, 0);

    // clear at T+2 with a simultaneous frame_tick
    @(negedge clk);
    a_tick_in = 1'b1;
    @(negedge clk);
    a_tick_in = 1'b0;
    @(negedge clk);
    a_clear = 1'b1;
    a_tick_in = 1'b1;
    @(negedge clk);
    a_clear = 1'b0;
    a_tick_in = 1'b0;
    tick_no = 0;
    exp_count = 0;
    check("clear_state", a_dbg_state, ST_IDLE);
    check("clear_busy", a_busy, 0);
    check("clear_spawn_count", a_spawn_count, 0);
    check("clear_overflow", a_overflow, 0);
    for (int i = 0; i < 4; i++) a_slot(i, 1'b0, 0, 0);
    repeat (6) @(negedge clk);
    check("clear_tick_ignored", a_busy, 0);

    // timer was reloaded: next spawn after another 40 ticks, count restarts
    a_rand = 32'h0000_0005;
    a_ticks(40);
    check("post_clear_count", a_spawn_count, 1);
    a_slot(0, 1'b1, 639, 52);

    // DUT b: fill the table, then overflow on the 5th spawn
    for (int k = 0; k < 4; k++) b_tick();
    check("b_overflow_0", b_overflow, 0);
    check("b_count_4", b_spawn_count, 4);
    for (int i = 0; i < 4; i++) b_slot(i, 636 + i, 32);
    b_tick();
    check("b_overflow_1", b_overflow, 1);
    check("b_count_5", b_spawn_count, 5);
    check("b_pulses_5", b_pulses, 5);
    for (int i = 0; i < 4; i++) b_slot(i, 635 + i, 32);

`ifdef OBSTACLE_COLLIDE_EN
    // gap_top=100 (rand 17), helicopter column at x=200
    a_clear_pulse();
    a_rand = 32'd17;
    a_heli_x = 10'd200;
    a_heli_y = 9'd150;
    a_ticks(150);
    check("hit_inside_gap", a_hit, 0);
    a_heli_y = 9'd50;
    a_ticks(40);
    check("hit_above_gap", a_hit, 1);
    @(negedge clk);
    aclr = 1'b0;
    #1;
    check("hit_after_aclr", a_hit, 0);
    @(negedge clk);
    aclr = 1'b1;
`endif

    repeat (4) @(negedge clk);
    check("exp_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/obstacle_spawner.md
# obstacle_spawner

Downstream consumer of the 6-bit pseudo-random shift register in the helicopter game. On every frame tick it scrolls a small table of active obstacles leftward, retires obstacles that leave the screen and periodically spawns a new one. Each new obstacle's gap position is derived from the random value. It pulses the shift register's write enable once per consumed value and exposes the table through an indexed read port to the renderer.

## Interface
Parameters:
- NUM_OBS, 4: obstacle table slots (power of 2, 2..8).
- SCREEN_W, 640: spawn x coordinate is SCREEN_W-1.
- SPEED, 4: pixels moved left per frame.
- SPAWN_FRAMES, 40: frames between spawns.
- GAP_MIN, 32: minimum gap_top.
- GAP_SCALE, 4: multiplier applied to rand[5:0].

Ports:
- clk  in  1  system clock.
- aclr  in  1  asynchronous active-low reset.
- clear  in  1  synchronous restart; invalidates all slots and reloads counters.
- run  in  1  game active; frame ticks are ignored while low.
- frame_tick  in  1  one-cycle pulse per video frame.
- rand_in  in  32  shift register output; only bits [5:0] are used.
- rand_en  out  1  write enable to the shift register; one-cycle pulse per spawn.
- busy  out  1  high while a frame update is in progress.
- rd_idx  in  $clog2(NUM_OBS)  slot select.
- rd_valid  out  1  selected slot is occupied.
- rd_x  out  10  selected slot x.
- rd_gap_top  out  9  selected slot gap top.
- spawn_count  out  16  obstacles spawned since clear; saturates at 0xFFFF.
- overflow  out  1  sticky; set when a spawn finds no free slot.

## Operation
- FSM states: IDLE, SCROLL, SPAWN.
- IDLE:
  - frame_tick && run && !clear goes to SCROLL with slot pointer 0.
  - frame_tick while busy, or with run low, is ignored.
- SCROLL: handles one slot per cycle.
  - A valid slot with x < SPEED is cleared (retired).
  - Any other valid slot gets x -= SPEED.
  - After slot NUM_OBS-1, decrement spawn_timer. If it reaches 0, reload SPAWN_FRAMES and go to SPAWN; otherwise go to IDLE.
- SPAWN:
  - Select the lowest-index free slot.
  - Write x = SCREEN_W-1 and gap_top = GAP_MIN + rand_in[5:0]*GAP_SCALE (9-bit, range 32..284), and set valid.
  - Pulse rand_en and increment spawn_count.
  - If no slot is free: no write and overflow=1, but rand_en still pulses. Return to IDLE.
- clear (any state): all valid=0, spawn_timer=SPAWN_FRAMES, spawn_count=0, overflow=0, FSM to IDLE. clear has priority over frame_tick.
- aclr low mid-frame: immediate return to reset values; the partial update is discarded.
- The read port is combinational from the table. Values may change during busy; the renderer samples while busy=0.

## Timing
- Reset values:
  - busy=0, rand_en=0, spawn_count=0, overflow=0.
  - All slots valid=0, x=0, gap_top=0.
  - rd_valid=0, spawn_timer=SPAWN_FRAMES, FSM IDLE.
- frame_tick is sampled at edge T; busy=1 from T+1.
- Slot i is written at edge T+1+i.
- The SPAWN write and the rand_en pulse occur in the same cycle, at edge T+1+NUM_OBS. rand_in is sampled in that cycle, before the shift register advances.
- busy=0 by cycle T+1+NUM_OBS without a spawn, or T+2+NUM_OBS with one.
- Worst-case frame latency: NUM_OBS+2 cycles.

## Configuration
- OBSTACLE_COLLIDE_EN defined:
  - Adds inputs heli_y[8:0] and heli_x[9:0], and output hit (1 bit).
  - During SCROLL, for a valid slot with post-move x within [heli_x, heli_x+15], hit=1 if heli_y < gap_top or heli_y > gap_top+GAP_H-1.
  - hit is sticky until clear or reset; GAP_H=96 comes from the package.
- Undefined: none of these ports exist; no collision logic is generated.

## Structure
- obstacle_pkg:
  - typedef obs_t {valid, x[9:0], gap_top[8:0]}.
  - FSM state enum, GAP_H, X_W=10, Y_W=9.
- Sub-module obstacle_table: NUM_OBS-entry register file.
  - One write port (index, data, clear_all) and one combinational read port, both async-reset.
  - The FSM, timers and the optional collision logic stay in obstacle_spawner.

## Test plan
- Reset, then release: all outputs at reset values, rd_valid=0 for every idx, rand_en never pulses without a frame_tick.
- run=1, rand_in=0x00000005, 40 frame ticks: exactly one rand_en pulse, on the 40th tick at T+5. Slot 0 then reads x=639, gap_top=52. busy lasts 5 cycles on that frame and 4 on the others.
- 10 further ticks after the spawn: slot 0 x=599. Continue until x<4: the slot retires on the next tick, with rd_valid=0.
- Fill all 4 slots, force a 5th spawn before any retires (SPAWN_FRAMES=1, SPEED=1): overflow=1, rand_en pulses, table unchanged, spawn_count=5.
- clear asserted mid-SCROLL at T+2: FSM returns to IDLE, all slots invalid, spawn_count=0, no rand_en pulse. A frame_tick asserted together with clear is ignored.
- OBSTACLE_COLLIDE_EN with a slot at gap_top=100 that scrolls into heli_x=200:
  - heli_y=50: hit=1 on the covering frame.
  - heli_y=150: hit stays 0.
  - aclr low resets hit.
